apb_timer_arbiter: RTL

- Two-requester APB master that shares the timer register block's APB slave port between two internal agents, e.g. a CPU bridge (port 0) and a hardware config sequencer (port 1).
- Accepts simple req/done transactions, arbitrates round-robin and runs a full APB SETUP/ACCESS cycle honouring PREADY.
- Returns read data and PSLVERR per requester.

---
 rtl/apb_timer_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/apb_timer_arbiter.sv
// Two-port round-robin APB master: shares one APB slave between two req/done agents.
// Optional ACCESS watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_timer_arbiter #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  err0,
  output logic                  err1,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  state_t                r_state, w_next;
  logic                  r_last, r_port;
  logic                  r_psel, r_penable, r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_gnt0, r_gnt1, r_done0, r_done1, r_err0, r_err1;
  logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1;
  logic                  w_grant_valid, w_grant_port, w_complete, w_timeout;

  // On a tie the port that did not win last time gets the bus.
  assign w_grant_valid = req0 | req1;
  assign w_grant_port  = (req0 & req1) ? ~r_last : req1;
  assign w_complete    = (r_state == S_ACCESS) & (PREADY | w_timeout);

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_tmo_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                             r_tmo_cnt <= '0;
    else if (r_state == S_SETUP)              r_tmo_cnt <= '0;
    else if (r_state == S_ACCESS && !PREADY)  r_tmo_cnt <= r_tmo_cnt + CW'(1);
  end

  // Fires on the edge that would make the wait count reach the limit; PREADY wins a tie.
  assign w_timeout = (r_state == S_ACCESS) & ~PREADY &
                     (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_grant_valid) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (w_complete) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_last    <= 1'b1;
      r_port    <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_grant_valid) begin
          r_port    <= w_grant_port;
          r_last    <= w_grant_port;
          r_psel    <= 1'b1;
          r_penable <= 1'b0;
          r_pwrite  <= w_grant_port ? we1    : we0;
          r_paddr   <= w_grant_port ? addr1  : addr0;
          r_pwdata  <= w_grant_port ? wdata1 : wdata0;
          r_gnt0    <= ~w_grant_port;
          r_gnt1    <= w_grant_port;
        end
        S_SETUP: r_penable <= 1'b1;
        S_ACCESS: if (w_complete) begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_pwrite  <= 1'b0;
          // Only the owning port's result registers move; writes keep old rdata.
          if (!r_port) begin
            r_done0 <= 1'b1;
            r_err0  <= w_timeout | PSLVERR;
            if (!r_pwrite) r_rdata0 <= w_timeout ? '0 : PRDATA;
          end else begin
            r_done1 <= 1'b1;
            r_err1  <= w_timeout | PSLVERR;
            if (!r_pwrite) r_rdata1 <= w_timeout ? '0 : PRDATA;
          end
        end
        S_DONE: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign PSEL    = r_psel;
  assign PENABLE = r_penable;
  assign PWRITE  = r_pwrite;
  assign PADDR   = r_paddr;
  assign PWDATA  = r_pwdata;
  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign done0   = r_done0;
  assign done1   = r_done1;
  assign err0    = r_err0;
  assign err1    = r_err1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;

endmodule
